hash_msg_feeder: RTL and testbench

- Upstream stage of the lightweight hash core (4-byte message block, 4-byte IV, start/done handshake, 4-byte digest).
- Accepts an arbitrary-length byte stream and packs it into 4-byte blocks, applying 10* padding.
- Drives the core one block at a time and chains each block digest in as the IV of the next block (Merkle-Damgard).
- Presents the final digest on a valid/ready output.

---
 rtl/hash_msg_feeder.sv | 139 +++++++++++++
 tb/tb_hash_msg_feeder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hash_msg_feeder.sv
// Byte-stream front end for the 4-byte hash core: packs bytes into blocks with 10* padding,
// issues them one at a time and chains each block digest into the next block's IV.
module hash_msg_feeder #(
  parameter logic [31:0] IV0   = 32'h0123_4567,
  parameter int          CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  core_start,
  output logic [0:3][7:0]       core_m,
  output logic [0:3][7:0]       core_iv,
  input  logic [0:3][7:0]       core_d,
  input  logic                  core_done,
  output logic                  dig_valid,
  input  logic                  dig_ready,
  output logic [0:3][7:0]       dig,
  output logic [CNT_W-1:0]      blk_cnt
);

  typedef enum logic [1:0] {ST_COLLECT, ST_ISSUE, ST_WAIT, ST_OUT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [0:3][7:0]  blk_q, blk_d;
  logic [0:3][7:0]  chain_q, chain_d;
  logic [0:3][7:0]  core_m_q, core_iv_q;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             final_q, final_d;
  logic             pad_blk_q, pad_blk_d;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values of the previous cycle regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_COLLECT;
      idx_q     <= '0;
      blk_q     <= '0;
      chain_q   <= IV0;
      blk_cnt_q <= '0;
      final_q   <= 1'b0;
      pad_blk_q <= 1'b0;
      core_m_q  <= '0;
      core_iv_q <= IV0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      blk_q     <= blk_d;
      chain_q   <= chain_d;
      blk_cnt_q <= blk_cnt_d;
      final_q   <= final_d;
      pad_blk_q <= pad_blk_d;
      // Core operands are captured on entry to ISSUE so they stay put while chain updates on done.
      if (state_d == ST_ISSUE && state_q != ST_ISSUE) begin
        core_m_q  <= blk_d;
        core_iv_q <= chain_d;
      end
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    blk_d     = blk_q;
    chain_d   = chain_q;
    blk_cnt_d = blk_cnt_q;
    final_d   = final_q;
    pad_blk_d = pad_blk_q;
    unique case (state_q)
      ST_COLLECT: begin
        if (in_valid) begin
          blk_d[idx_q] = in_data;
          idx_d        = idx_q + 2'd1;
          if (in_last && idx_q == 2'd3) begin
            pad_blk_d = 1'b1;
            final_d   = 1'b0;
            state_d   = ST_ISSUE;
          end else if (in_last) begin
            for (int i = 0; i < 4; i++) begin
              if (i == int'(idx_q) + 1)     blk_d[i[1:0]] = 8'h80;
              else if (i > int'(idx_q) + 1) blk_d[i[1:0]] = 8'h00;
            end
            final_d = 1'b1;
            state_d = ST_ISSUE;
          end else if (idx_q == 2'd3) begin
            final_d = 1'b0;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (core_done) begin
          chain_d   = core_d;
          blk_cnt_d = blk_cnt_q + 1'b1;
          if (final_q) begin
            state_d = ST_OUT;
          end else if (pad_blk_q) begin
            blk_d     = 32'h8000_0000;
            pad_blk_d = 1'b0;
            final_d   = 1'b1;
            state_d   = ST_ISSUE;
          end else begin
            idx_d   = '0;
            state_d = ST_COLLECT;
          end
        end
      end
      ST_OUT: begin
        if (dig_ready) begin
          chain_d   = IV0;
          blk_cnt_d = '0;
          idx_d     = '0;
          blk_d     = '0;
          final_d   = 1'b0;
          state_d   = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_comb begin
    in_ready   = !rst && (state_q == ST_COLLECT);
    core_start = !rst && (state_q == ST_ISSUE);
    dig_valid  = !rst && (state_q == ST_OUT);
  end

  assign core_m  = core_m_q;
  assign core_iv = core_iv_q;
  assign dig     = chain_q;
  assign blk_cnt = blk_cnt_q;

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Directed bench for hash_msg_feeder with a fixed-latency mock core (d = m ^ iv ^ 5A per byte).
module tb_hash_msg_feeder;

  localparam logic [31:0] IV0 = 32'h0123_4567;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, in_last;
  logic [7:0]      in_data;
  logic            core_start, core_done;
  logic [0:3][7:0] core_m, core_iv, core_d;
  logic            dig_valid, dig_ready;
  logic [0:3][7:0] dig;
  logic [15:0]     blk_cnt;

  int n_checks = 0;
  int n_err    = 0;

  // Mock core state and start log (written only by the mock process).
  int          mock_cnt = 0;
  int          n_starts = 0;
  logic [31:0] log_m  [0:7];
  logic [31:0] log_iv [0:7];

  hash_msg_feeder #(.IV0(IV0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .core_start(core_start), .core_m(core_m), .core_iv(core_iv),
    .core_d(core_d), .core_done(core_done),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig(dig), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  // Mock core: done pulses 26 cycles after start; runs on regardless of the feeder's reset.
  always @(negedge clk) begin
    core_done = 1'b0;
    if (mock_cnt > 0) begin
      mock_cnt = mock_cnt - 1;
      if (mock_cnt == 0) begin
        core_done = 1'b1;
        core_d    = core_m ^ core_iv ^ 32'h5A5A_5A5A;
      end
    end
    if (core_start) begin
      log_m[n_starts % 8]  = core_m;
      log_iv[n_starts % 8] = core_iv;
      n_starts = n_starts + 1;
      mock_cnt = 26;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_dig();
    int t = 0;
    while (!dig_valid && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("dig_valid_timeout", 32'(dig_valid), 32'd1);
  endtask

  task automatic consume();
    dig_ready = 1'b1;
    @(negedge clk);
    dig_ready = 1'b0;
  endtask

  int base;
  int bad;
  logic [31:0] held;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    dig_ready = 1'b0; core_done = 1'b0; core_d = '0;

    // Reset held for 3 cycles.
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_dig_valid", 32'(dig_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_blk_cnt", 32'(blk_cnt), 32'd0);

    // 3-byte message: single padded block.
    base = n_starts;
    send_byte(8'h61, 1'b0); send_byte(8'h62, 1'b0); send_byte(8'h63, 1'b1);
    wait_dig();
    check("m3_starts", 32'(n_starts - base), 32'd1);
    check("m3_core_m", log_m[base % 8], 32'h6162_6380);
    check("m3_core_iv", log_iv[base % 8], IV0);
    check("m3_dig", dig, 32'h3A1B_7CBD);
    check("m3_blk_cnt", 32'(blk_cnt), 32'd1);
    consume();
    check("m3_cnt_clear", 32'(blk_cnt), 32'd0);

    // 4-byte message: full block then a pure padding block; digest held under backpressure.
    base = n_starts;
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b1);
    wait_dig();
    check("m4_starts", 32'(n_starts - base), 32'd2);
    check("m4_b1_m", log_m[base % 8], 32'h0102_0304);
    check("m4_b1_iv", log_iv[base % 8], IV0);
    check("m4_b2_m", log_m[(base + 1) % 8], 32'h8000_0000);
    check("m4_b2_iv", log_iv[(base + 1) % 8], 32'h5A7B_1C39);
    check("m4_dig", dig, 32'h8021_4663);
    check("m4_blk_cnt", 32'(blk_cnt), 32'd2);
    held = dig;
    bad  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!dig_valid || dig !== held || in_ready) bad++;
    end
    check("m4_hold_bad_cycles", 32'(bad), 32'd0);
    consume();

    // 5-byte message: second block carries the tail byte plus padding.
    base = n_starts;
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0); send_byte(8'h05, 1'b1);
    wait_dig();
    check("m5_starts", 32'(n_starts - base), 32'd2);
    check("m5_b1_iv", log_iv[base % 8], IV0);
    check("m5_b2_m", log_m[(base + 1) % 8], 32'h0580_0000);
    check("m5_b2_iv", log_iv[(base + 1) % 8], 32'h5A7B_1C39);
    check("m5_dig", dig, 32'h05A1_4663);
    check("m5_blk_cnt", 32'(blk_cnt), 32'd2);
    consume();

    // Reset while waiting on the core; the late done must be ignored.
    send_byte(8'h61, 1'b0); send_byte(8'h62, 1'b0); send_byte(8'h63, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = n_starts;
    bad  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dig_valid || !in_ready) bad++;
    end
    check("abort_bad_cycles", 32'(bad), 32'd0);
    check("abort_starts", 32'(n_starts - base), 32'd0);
    check("abort_blk_cnt", 32'(blk_cnt), 32'd0);
    base = n_starts;
    send_byte(8'h61, 1'b0); send_byte(8'h62, 1'b0); send_byte(8'h63, 1'b1);
    wait_dig();
    check("abort_new_iv", log_iv[base % 8], IV0);
    check("abort_new_dig", dig, 32'h3A1B_7CBD);
    consume();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
